baccarat_round_ctrl: RTL and testbench
======================================

# baccarat_round_ctrl

Sequencing controller for one baccarat round. Issues card-load strobes to the six external card registers (player 1–3, dealer 1–3) in dealing order. Consumes the two hand scores produced by the per-hand scoring logic, applies the natural and third-card rules, and drives the win lights. Sits between the top-level card/score datapath and the board's step input (a debounced key pulse).

## Interface
- No parameters. State encoding and rank constants come from the shared package.
- `slow_clock`  in  1  sole clock; all state changes occur on its rising edge.
- `resetb`  in  1  asynchronous, active-low reset.
- `step`  in  1  advance strobe, one `slow_clock` cycle wide; the FSM moves only when high.
- `pscore`  in  4  player hand score, 0–9, combinational from the player card registers.
- `dscore`  in  4  dealer hand score, 0–9.
- `pcard3`  in  4  rank of the player's third card: 1–13, where 11/12/13 are J/Q/K.
- `load_pcard1`, `load_pcard2`, `load_pcard3`  out  1 each  player card register load enables.
- `load_dcard1`, `load_dcard2`, `load_dcard3`  out  1 each  dealer card register load enables.
- `player_win_light`, `dealer_win_light`  out  1 each  result lights; both high on a tie.
- `round_done`  out  1  high while in S_DONE.
- `clear_cards`  out  1  clear strobe for all card registers (only when the macro is defined; tied 0 otherwise).

## Operation
- States, in order: S_P1, S_D1, S_P2, S_D2, S_EVAL, S_P3, S_BEVAL, S_D3, S_DONE. Reset state is S_P1.
- In each load state (S_P1/S_D1/S_P2/S_D2/S_P3/S_D3), `load_x = (state==x) & step`.
  - The external register captures on the same edge as the FSM transition.
  - From S_P1–S_D2 the next state is the next state in order.
  - S_P3 goes to S_BEVAL; S_D3 goes to S_DONE.
- S_EVAL, on `step`:
  - If `pscore` ≥ 8 or `dscore` ≥ 8 (natural), go to S_DONE.
  - Else if `pscore` ≤ 5, go to S_P3.
  - Else if `dscore` ≤ 5, go to S_D3.
  - Else go to S_DONE.
- S_BEVAL, on `step`: compute `p3v` = `pcard3` if `pcard3` ≤ 9, else 0. The banker draws (go to S_D3) when:
  - `dscore` 0–2: always.
  - `dscore` 3: `p3v` ≠ 8.
  - `dscore` 4: `p3v` in 2–7.
  - `dscore` 5: `p3v` in 4–7.
  - `dscore` 6: `p3v` in 6–7.
  - `dscore` 7: never.
  - Otherwise go to S_DONE.
- S_DONE:
  - `player_win_light = (pscore >= dscore)` and `dealer_win_light = (dscore >= pscore)`, combinational from state and scores.
  - Both lights are 0 in every other state.
- `step` held high advances one state per cycle. A `step` arriving in S_EVAL or S_BEVAL does not need the scores to have settled in an earlier cycle: they settle one cycle after the last load.
- Scores outside 0–9 never occur. Behaviour for such inputs is unspecified, but no state is left unreachable-stuck.

## Timing
- Reset (async assert, sync release): state S_P1; all loads, lights, `round_done` and `clear_cards` are 0.
- Load strobe latency is 0 cycles from `step` (Mealy). The corresponding score is valid 1 cycle later.
- Result lights become valid in the first cycle of S_DONE.
- Minimum round length: 5 `step`s (natural). Maximum: 8 `step`s.
- `resetb` asserted mid-round (any state) returns to S_P1 immediately, with no pending load pulse.

## Configuration
- `BACCARAT_ROUND_RESTART_EN` defined:
  - In S_DONE, `step` asserts `clear_cards` for that cycle and returns to S_P1, starting a new round.
  - The lights drop on leaving S_DONE.
- Undefined: S_DONE is terminal until reset; `clear_cards` is constant 0.

## Structure
- Package `baccarat_pkg` holds:
  - The state enum (4-bit, `typedef enum logic [3:0]`).
  - `NATURAL_MIN = 8`, `DRAW_MAX = 5`, `FACE_MIN = 10`.
- One sub-module: `banker_draw_rule` (combinational; inputs `dscore` and `pcard3`, output `draw`). It is unit-tested separately.

## Test plan
- **Reset and basic dealing.** Reset, then 4 `step`s → single-cycle pulses on `load_pcard1`, `load_dcard1`, `load_pcard2`, `load_dcard2`, in that order. All other outputs stay 0.
- **Natural.** In S_EVAL with `pscore`=8, `dscore`=3, `step` → S_DONE, `player_win_light`=1, `dealer_win_light`=0, no third-card load.
- **Both draw.** `pscore`=4, `dscore`=6, `step` → `load_pcard3`. Then with `pcard3`=7, `step` → `load_dcard3`, then `step` → S_DONE.
- **Player stands, banker draws.** `pscore`=7, `dscore`=5, `step` in S_EVAL → `load_dcard3` on the next `step`. Tie at S_DONE (7/7) → both lights 1.
- **Banker rule edges.**
  - `dscore`=3, `pcard3`=8 → S_DONE with no `load_dcard3`.
  - `dscore`=4, `pcard3`=12 (counts as 0) → stand.
  - `dscore`=6, `pcard3`=6 → draw.
- **Reset mid-round and restart.** `resetb` low while in S_P3 → outputs 0 in the same cycle; after release, the next `step` gives `load_pcard1`. With the macro defined, `step` in S_DONE → one `clear_cards` pulse, state returns to S_P1.

Source files
------------

// File: rtl/baccarat_round_ctrl_pkg.sv
// Shared state encoding and rank/score constants for the baccarat round controller.
package baccarat_pkg;

    typedef enum logic [3:0] {
        S_P1    = 4'd0,
        S_D1    = 4'd1,
        S_P2    = 4'd2,
        S_D2    = 4'd3,
        S_EVAL  = 4'd4,
        S_P3    = 4'd5,
        S_BEVAL = 4'd6,
        S_D3    = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    localparam logic [3:0] NATURAL_MIN = 4'd8;
    localparam logic [3:0] DRAW_MAX    = 4'd5;
    localparam logic [3:0] FACE_MIN    = 4'd10;

    // Baccarat point value of a rank: tens and faces count as zero.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank >= FACE_MIN) ? 4'd0 : rank;
    endfunction

endpackage

// File: rtl/baccarat_round_ctrl_if.sv
// Step/score inputs and load/light outputs of the round controller.
interface baccarat_round_ctrl_if;

    logic       step;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       player_win_light;
    logic       dealer_win_light;
    logic       round_done;
    logic       clear_cards;

    modport master (
        output step, pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light, round_done, clear_cards
    );

    modport slave (
        input  step, pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light, round_done, clear_cards
    );

endinterface

// File: rtl/baccarat_round_ctrl_banker_draw_rule.sv
// Banker third-card tableau: decides whether the dealer draws given its score
// and the rank of the player's third card.
module banker_draw_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] p3v;

    assign p3v = card_value(pcard3);

    always_comb begin
        draw = 1'b0;
        unique case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (p3v != 4'd8);
            4'd4:             draw = (p3v >= 4'd2) && (p3v <= 4'd7);
            4'd5:             draw = (p3v >= 4'd4) && (p3v <= 4'd7);
            4'd6:             draw = (p3v >= 4'd6) && (p3v <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_round_ctrl.sv
// Baccarat round sequencer: deals, applies natural/third-card rules, drives lights.
// Optional restart from S_DONE is enabled by defining BACCARAT_ROUND_RESTART_EN.
module baccarat_round_ctrl
    import baccarat_pkg::*;
(
    input  logic                  slow_clock,
    input  logic                  resetb,
    baccarat_round_ctrl_if.slave  bus
);

    state_t state, state_nxt;
    logic   bank_draw;
    logic   lp1, lp2, lp3, ld1, ld2, ld3;
    logic   in_done;
`ifdef BACCARAT_ROUND_RESTART_EN
    logic   clr;
`endif

    banker_draw_rule u_draw (
        .dscore (bus.dscore),
        .pcard3 (bus.pcard3),
        .draw   (bank_draw)
    );

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) state <= S_P1;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        lp1 = 1'b0; lp2 = 1'b0; lp3 = 1'b0;
        ld1 = 1'b0; ld2 = 1'b0; ld3 = 1'b0;
`ifdef BACCARAT_ROUND_RESTART_EN
        clr = 1'b0;
`endif
        unique case (state)
            S_P1:    if (bus.step) begin lp1 = 1'b1; state_nxt = S_D1;  end
            S_D1:    if (bus.step) begin ld1 = 1'b1; state_nxt = S_P2;  end
            S_P2:    if (bus.step) begin lp2 = 1'b1; state_nxt = S_D2;  end
            S_D2:    if (bus.step) begin ld2 = 1'b1; state_nxt = S_EVAL; end
            S_EVAL: begin
                if (bus.step) begin
                    if (bus.pscore >= NATURAL_MIN || bus.dscore >= NATURAL_MIN)
                        state_nxt = S_DONE;
                    else if (bus.pscore <= DRAW_MAX)
                        state_nxt = S_P3;
                    else if (bus.dscore <= DRAW_MAX)
                        state_nxt = S_D3;
                    else
                        state_nxt = S_DONE;
                end
            end
            S_P3:    if (bus.step) begin lp3 = 1'b1; state_nxt = S_BEVAL; end
            S_BEVAL: if (bus.step) state_nxt = bank_draw ? S_D3 : S_DONE;
            S_D3:    if (bus.step) begin ld3 = 1'b1; state_nxt = S_DONE; end
            S_DONE: begin
`ifdef BACCARAT_ROUND_RESTART_EN
                if (bus.step) begin
                    clr       = 1'b1;
                    state_nxt = S_P1;
                end
`endif
            end
            // Unused encodings recover to the start of a round.
            default: state_nxt = S_P1;
        endcase
    end

    // Mealy strobes are masked by reset so an asserted reset never leaks a load.
    assign bus.load_pcard1 = resetb & lp1;
    assign bus.load_dcard1 = resetb & ld1;
    assign bus.load_pcard2 = resetb & lp2;
    assign bus.load_dcard2 = resetb & ld2;
    assign bus.load_pcard3 = resetb & lp3;
    assign bus.load_dcard3 = resetb & ld3;

    assign in_done              = resetb & (state == S_DONE);
    assign bus.round_done       = in_done;
    assign bus.player_win_light = in_done & (bus.pscore >= bus.dscore);
    assign bus.dealer_win_light = in_done & (bus.dscore >= bus.pscore);

`ifdef BACCARAT_ROUND_RESTART_EN
    assign bus.clear_cards = resetb & clr;
`else
    assign bus.clear_cards = 1'b0;
`endif

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Self-checking bench for baccarat_round_ctrl: directed rule cases plus a
// randomized run against a card-counting reference model.
module tb_baccarat_round_ctrl;

    logic slow_clock = 1'b0;
    logic resetb;
    baccarat_round_ctrl_if bus ();

    baccarat_round_ctrl dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .bus        (bus)
    );

    always #5 slow_clock = ~slow_clock;

    int tests = 0;
    int fails = 0;

    // Reference model: how many of the first four cards are out, and which
    // decisions are still owed for this round.
    int m_dealt;
    bit m_evaluated, m_owe_p3, m_owe_bank, m_owe_d3, m_done;

    // Output vector: {lp1,ld1,lp2,ld2,lp3,ld3,pwin,dwin,done,clr}
    logic [9:0] dut_out;
    logic [9:0] last;
    assign dut_out = {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2, bus.load_dcard2,
                      bus.load_pcard3, bus.load_dcard3, bus.player_win_light,
                      bus.dealer_win_light, bus.round_done, bus.clear_cards};

    // Banker tableau as a per-score mask over the player's third-card value.
    function automatic bit bank_draws(input int d, input int c3);
        int v;
        logic [9:0] mask;
        v = (c3 > 9) ? 0 : c3;
        case (d)
            0, 1, 2: mask = 10'h3FF;
            3:       mask = 10'h3FF & ~(10'd1 << 8);
            4:       mask = 10'b0011111100;
            5:       mask = 10'b0011110000;
            6:       mask = 10'b0011000000;
            default: mask = 10'h000;
        endcase
        return mask[v];
    endfunction

    function automatic logic [9:0] model_out(input bit st, input int p, input int d);
        logic [9:0] o;
        o = '0;
        if (m_done) begin
            o[3] = (p >= d);
            o[2] = (d >= p);
            o[1] = 1'b1;
`ifdef BACCARAT_ROUND_RESTART_EN
            o[0] = st;
`endif
        end else if (st) begin
            if (m_dealt < 4)                                 o[9 - m_dealt] = 1'b1;
            else if (m_evaluated && m_owe_p3)                o[5] = 1'b1;
            else if (m_evaluated && !m_owe_bank && m_owe_d3) o[4] = 1'b1;
        end
        return o;
    endfunction

    task automatic model_reset();
        m_dealt = 0; m_evaluated = 0; m_owe_p3 = 0; m_owe_bank = 0; m_owe_d3 = 0; m_done = 0;
    endtask

    task automatic model_step(input bit st, input int p, input int d, input int c3);
        if (!st) return;
        if (m_done) begin
`ifdef BACCARAT_ROUND_RESTART_EN
            model_reset();
`endif
        end else if (m_dealt < 4) begin
            m_dealt++;
        end else if (!m_evaluated) begin
            m_evaluated = 1;
            if (p >= 8 || d >= 8) m_done = 1;
            else if (p <= 5)      m_owe_p3 = 1;
            else if (d <= 5)      m_owe_d3 = 1;
            else                  m_done = 1;
        end else if (m_owe_p3) begin
            m_owe_p3 = 0; m_owe_bank = 1;
        end else if (m_owe_bank) begin
            m_owe_bank = 0;
            if (bank_draws(d, c3)) m_owe_d3 = 1;
            else                   m_done = 1;
        end else if (m_owe_d3) begin
            m_owe_d3 = 0; m_done = 1;
        end
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, compare against the model, advance model at posedge.
    task automatic cyc(input bit st, input int p, input int d, input int c3);
        @(negedge slow_clock);
        bus.step = st; bus.pscore = 4'(p); bus.dscore = 4'(d); bus.pcard3 = 4'(c3);
        #1;
        last = dut_out;
        check("cycle", last, model_out(st, p, d));
        @(posedge slow_clock);
        model_step(st, p, d, c3);
    endtask

    // Reset asserted with step held high: no load may leak out.
    task automatic do_reset();
        @(negedge slow_clock);
        bus.step = 1'b1;
        resetb = 1'b0;
        #1;
        check("reset_outputs", dut_out, 10'b0);
        model_reset();
        @(negedge slow_clock);
        resetb = 1'b1;
        bus.step = 1'b0;
    endtask

    task automatic deal4();
        logic [9:0] e;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 1);
            e = 10'b1000000000;
            check("deal_order", last, e >> i);
        end
    endtask

    int idle;

    initial begin
        resetb = 1'b0;
        bus.step = 1'b0; bus.pscore = '0; bus.dscore = '0; bus.pcard3 = 4'd1;
        model_reset();
        #12;
        check("reset_state", dut_out, 10'b0);
        @(negedge slow_clock);
        resetb = 1'b1;

        // Pin the model's tableau against hand-read values.
        check("rule_3_8",  {9'b0, bank_draws(3, 8)},  10'd0);
        check("rule_4_12", {9'b0, bank_draws(4, 12)}, 10'd0);
        check("rule_6_6",  {9'b0, bank_draws(6, 6)},  10'd1);
        check("rule_3_13", {9'b0, bank_draws(3, 13)}, 10'd1);

        // Basic dealing, then an idle cycle.
        deal4();
        cyc(0, 0, 0, 1); check("idle_eval", last, 10'b0);

        // Natural 8 vs 3.
        cyc(1, 8, 3, 1); check("natural_step", last, 10'b0);
        cyc(0, 8, 3, 1); check("natural_done", last, 10'b0000001010);

        // Both draw, pcard3=7 with dealer 6.
        do_reset(); deal4();
        cyc(1, 4, 6, 1); check("both_eval", last, 10'b0);
        cyc(1, 4, 6, 7); check("both_p3",   last, 10'b0000100000);
        cyc(1, 4, 6, 7); check("both_beval", last, 10'b0);
        cyc(1, 4, 6, 7); check("both_d3",   last, 10'b0000010000);
        cyc(0, 4, 6, 7); check("both_done", last, 10'b0000000110);

        // Player stands on 7, banker draws on 5, tie 7/7.
        do_reset(); deal4();
        cyc(1, 7, 5, 1); check("stand_eval", last, 10'b0);
        cyc(1, 7, 5, 1); check("stand_d3",   last, 10'b0000010000);
        cyc(0, 7, 7, 1); check("tie_lights", last, 10'b0000001110);

        // Banker 3 vs third card 8: stand.
        do_reset(); deal4();
        cyc(1, 2, 3, 1); cyc(1, 2, 3, 8); check("e38_p3", last, 10'b0000100000);
        cyc(1, 2, 3, 8); check("e38_beval", last, 10'b0);
        cyc(0, 2, 3, 8); check("e38_done",  last, 10'b0000000110);

        // Banker 4 vs queen: stand.
        do_reset(); deal4();
        cyc(1, 2, 4, 1); cyc(1, 2, 4, 12); cyc(1, 2, 4, 12);
        cyc(0, 2, 4, 12); check("e412_done", last, 10'b0000000110);

        // Banker 6 vs 6: draw.
        do_reset(); deal4();
        cyc(1, 1, 6, 1); cyc(1, 1, 6, 6); cyc(1, 1, 6, 6);
        cyc(1, 1, 6, 6); check("e66_d3", last, 10'b0000010000);

        // Reset while in S_P3, then a fresh round.
        do_reset(); deal4();
        cyc(1, 3, 3, 1);
        do_reset();
        cyc(1, 3, 3, 1); check("after_reset_p1", last, 10'b1000000000);

`ifdef BACCARAT_ROUND_RESTART_EN
        do_reset(); deal4();
        cyc(1, 9, 1, 1);
        cyc(1, 9, 1, 1); check("restart_clear", last, 10'b0000001011);
        cyc(1, 9, 1, 1); check("restart_p1",    last, 10'b1000000000);
`endif

        // Randomized run against the model.
        do_reset();
        idle = 0;
        for (int n = 0; n < 3000; n++) begin
            idle = m_done ? idle + 1 : 0;
            if ($urandom_range(0, 199) == 0 || idle > 4) begin
                do_reset();
                idle = 0;
            end else begin
                cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9),
                    $urandom_range(0, 9), $urandom_range(1, 13));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
